// File: rtl/sd_cmd_pkg.sv
// Shared types and constants for the SD host command path: FSM states, frame sizes,
// CRC7 polynomial and default response timing.
package sd_cmd_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StSend,
        StTurn,
        StWaitStart,
        StReceive,
        StCheck,
        StAck
    } state_e;

    localparam int unsigned CMD_FRAME_BITS       = 48;
    localparam int unsigned CMD_PAYLOAD_BITS     = 40;
    localparam logic [6:0]  CRC7_POLY            = 7'h09;  // x^7 + x^3 + 1
    localparam int unsigned RESP_TIMEOUT_DEFAULT = 64;
    localparam int unsigned TURN_CYCLES_DEFAULT  = 2;
    localparam logic [5:0]  CMD_NO_RESP_INDEX    = 6'd0;

endpackage

// File: rtl/sd_crc7.sv
// Serial CRC7 (x^7 + x^3 + 1, init 0), one bit per enabled cycle; clear has priority.
module sd_crc7
    import sd_cmd_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       clear_i,
    input  logic       en_i,
    input  logic       bit_i,
    output logic [6:0] crc_o
);
    logic [6:0] crc_q, crc_d;
    logic       fb;

    always_comb begin
        fb    = crc_q[6] ^ bit_i;
        crc_d = crc_q;
        if (clear_i) begin
            crc_d = '0;
        end else if (en_i) begin
            crc_d = {crc_q[5:0], 1'b0} ^ (fb ? CRC7_POLY : 7'h00);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            crc_q <= '0;
        end else begin
            crc_q <= crc_d;
        end
    end

    assign crc_o = crc_q;

endmodule

// File: rtl/cmd_serial_host.sv
// SD command serialiser: sends a 48-bit command frame with CRC7 on CMD, then collects and
// CRC-checks the 48-bit response, handing the payload back over a four-phase handshake.
module cmd_serial_host
    import sd_cmd_pkg::*;
#(
    parameter int unsigned RESP_TIMEOUT = RESP_TIMEOUT_DEFAULT,
    parameter int unsigned TURN_CYCLES  = TURN_CYCLES_DEFAULT
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        req_in,
    input  logic [CMD_PAYLOAD_BITS-1:0] cmd_in,
    output logic                        ack_out,
    output logic [CMD_PAYLOAD_BITS-1:0] cmd_out,
    output logic                        serial_ready,
    output logic                        crc_err,
    output logic                        timeout_err,
    output logic                        cmd_pin_out,
    output logic                        cmd_pin_oe,
    input  logic                        cmd_pin_in
);
    localparam int unsigned TmoW = $clog2(RESP_TIMEOUT + 1);

    state_e                      state_q, state_d;
    logic [5:0]                  bit_cnt_q, bit_cnt_d;
    logic [TmoW-1:0]             tmo_cnt_q, tmo_cnt_d;
    logic [CMD_PAYLOAD_BITS-1:0] frame_q, frame_d;
    logic [CMD_FRAME_BITS-1:0]   rx_q, rx_d;
    logic [CMD_PAYLOAD_BITS-1:0] cmd_out_q, cmd_out_d;
    logic                        crc_err_q, crc_err_d;
    logic                        tmo_err_q, tmo_err_d;
    logic                        pin_q, pin_d;
    logic                        oe_q, oe_d;
    logic                        crc_clr, crc_en, crc_bit;
    logic [6:0]                  crc;
    logic [5:0]                  tx_idx;
    logic [2:0]                  crc_idx;

    sd_crc7 u_crc7 (
        .clk_i   (clock),
        .rst_i   (reset),
        .clear_i (crc_clr),
        .en_i    (crc_en),
        .bit_i   (crc_bit),
        .crc_o   (crc)
    );

    // Pin drive is registered, so SEND runs one cycle longer than the 48 bits on the line.
    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        tmo_cnt_d = tmo_cnt_q;
        frame_d   = frame_q;
        rx_d      = rx_q;
        cmd_out_d = cmd_out_q;
        crc_err_d = crc_err_q;
        tmo_err_d = tmo_err_q;
        pin_d     = 1'b1;
        oe_d      = 1'b0;
        crc_clr   = 1'b0;
        crc_en    = 1'b0;
        crc_bit   = cmd_pin_in;
        tx_idx    = 6'd39 - bit_cnt_q;
        crc_idx   = 3'(6'd46 - bit_cnt_q);

        unique case (state_q)
            StIdle: begin
                if (req_in) begin
                    frame_d   = cmd_in;
                    crc_clr   = 1'b1;
                    crc_err_d = 1'b0;
                    tmo_err_d = 1'b0;
                    bit_cnt_d = '0;
                    state_d   = StSend;
                end
            end
            StSend: begin
                bit_cnt_d = bit_cnt_q + 6'd1;
                if (bit_cnt_q < 6'd40) begin
                    oe_d    = 1'b1;
                    pin_d   = frame_q[tx_idx];
                    crc_en  = 1'b1;
                    crc_bit = frame_q[tx_idx];
                end else if (bit_cnt_q < 6'd47) begin
                    oe_d  = 1'b1;
                    pin_d = crc[crc_idx];
                end else if (bit_cnt_q == 6'd47) begin
                    oe_d  = 1'b1;
                    pin_d = 1'b1;
                end else begin
                    crc_clr   = 1'b1;
                    bit_cnt_d = '0;
                    tmo_cnt_d = '0;
                    if (frame_q[37:32] == CMD_NO_RESP_INDEX) begin
                        cmd_out_d = '0;
                        state_d   = StAck;
                    end else begin
                        state_d = StTurn;
                    end
                end
            end
            StTurn: begin
                bit_cnt_d = bit_cnt_q + 6'd1;
                if (bit_cnt_q == 6'(TURN_CYCLES - 1)) begin
                    state_d = StWaitStart;
                end
            end
            StWaitStart: begin
                if (!cmd_pin_in) begin
                    rx_d      = {rx_q[CMD_FRAME_BITS-2:0], cmd_pin_in};
                    crc_en    = 1'b1;
                    bit_cnt_d = 6'd1;
                    state_d   = StReceive;
                end else if (tmo_cnt_q == TmoW'(RESP_TIMEOUT)) begin
                    tmo_err_d = 1'b1;
                    cmd_out_d = '0;
                    state_d   = StAck;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + 1'b1;
                end
            end
            StReceive: begin
                rx_d      = {rx_q[CMD_FRAME_BITS-2:0], cmd_pin_in};
                crc_en    = (bit_cnt_q < 6'd40);
                bit_cnt_d = bit_cnt_q + 6'd1;
                if (bit_cnt_q == 6'd47) begin
                    state_d = StCheck;
                end
            end
            StCheck: begin
                cmd_out_d = rx_q[47:8];
                crc_err_d = (crc != rx_q[7:1]) || !rx_q[0];
                state_d   = StAck;
            end
            StAck: begin
                if (!req_in) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= StIdle;
            bit_cnt_q <= '0;
            tmo_cnt_q <= '0;
            frame_q   <= '0;
            rx_q      <= '0;
            cmd_out_q <= '0;
            crc_err_q <= 1'b0;
            tmo_err_q <= 1'b0;
            pin_q     <= 1'b1;
            oe_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            tmo_cnt_q <= tmo_cnt_d;
            frame_q   <= frame_d;
            rx_q      <= rx_d;
            cmd_out_q <= cmd_out_d;
            crc_err_q <= crc_err_d;
            tmo_err_q <= tmo_err_d;
            pin_q     <= pin_d;
            oe_q      <= oe_d;
        end
    end

    assign ack_out      = (state_q == StAck);
    assign serial_ready = (state_q == StIdle);
    assign cmd_out      = cmd_out_q;
    assign crc_err      = crc_err_q;
    assign timeout_err  = tmo_err_q;
    assign cmd_pin_out  = pin_q;
    assign cmd_pin_oe   = oe_q;

endmodule

// File: tb/tb_cmd_serial_host.sv
// Bench for cmd_serial_host: table of directed transactions, randomized transactions checked
// against a CRC-by-long-division model, and hand-written reset/hold sequences.
module tb_cmd_serial_host;

    logic        clock;
    logic        reset;
    logic        req_in;
    logic [39:0] cmd_in;
    logic        ack_out;
    logic [39:0] cmd_out;
    logic        serial_ready;
    logic        crc_err;
    logic        timeout_err;
    logic        cmd_pin_out;
    logic        cmd_pin_oe;
    logic        cmd_pin_in;

    int n_vec = 0;
    int n_err = 0;

    cmd_serial_host dut (
        .clock        (clock),
        .reset        (reset),
        .req_in       (req_in),
        .cmd_in       (cmd_in),
        .ack_out      (ack_out),
        .cmd_out      (cmd_out),
        .serial_ready (serial_ready),
        .crc_err      (crc_err),
        .timeout_err  (timeout_err),
        .cmd_pin_out  (cmd_pin_out),
        .cmd_pin_oe   (cmd_pin_oe),
        .cmd_pin_in   (cmd_pin_in)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // mode: 0 = card answers, 1 = line held high
    typedef struct {
        logic [5:0]  idx;
        logic [31:0] arg;
        int          mode;
        logic [39:0] resp;
        logic [6:0]  crc_xor;
        logic        end_bit;
        int          delay;
        int          hold;
        logic [47:0] exp_frame;
        logic [39:0] exp_cmd;
        logic        exp_crc_err;
        logic        exp_tmo;
    } vec_t;

    // CRC7 as the remainder of M(x)*x^7 divided by x^7+x^3+1.
    function automatic logic [6:0] crc7_ref(input logic [39:0] d);
        logic [46:0] r;
        logic [46:0] g;
        r = {d, 7'd0};
        for (int i = 46; i >= 7; i--) begin
            g = 47'h89 << (i - 7);
            if (r[i]) r = r ^ g;
        end
        return r[6:0];
    endfunction

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic run(input vec_t v);
        logic [39:0] cmd;
        logic [47:0] frame;
        logic [47:0] rframe;
        logic        ok;
        int          n;
        cmd = {2'b01, v.idx, v.arg};
        n = 0;
        while (!serial_ready && n < 300) begin
            step();
            n++;
        end
        check("ready_before_req", serial_ready, 1);
        req_in = 1'b1;
        cmd_in = cmd;
        step();
        check("accept", {serial_ready, cmd_pin_oe}, 2'b00);
        ok = 1'b1;
        for (int k = 1; k <= 48; k++) begin
            cmd_in = 40'({$urandom(), $urandom()});
            req_in = (k < 40) ? 1'($urandom()) : 1'b1;
            step();
            ok = ok & cmd_pin_oe;
            frame[48-k] = cmd_pin_out;
        end
        check("frame", frame, v.exp_frame);
        check("frame_oe", ok, 1);
        step();
        check("release", {cmd_pin_oe, cmd_pin_out}, 2'b01);
        if (v.idx != 6'd0) begin
            if (v.mode == 1) begin
                n = 0;
                while (!ack_out && n < 200) begin
                    step();
                    n++;
                end
                check("timeout_latency", n, 67);
            end else begin
                rframe = {v.resp, crc7_ref(v.resp) ^ v.crc_xor, v.end_bit};
                repeat (v.delay) step();
                ok = 1'b1;
                for (int b = 0; b < 48; b++) begin
                    cmd_pin_in = rframe[47-b];
                    step();
                    ok = ok & !cmd_pin_oe & !ack_out;
                end
                cmd_pin_in = 1'b1;
                check("resp_quiet", ok, 1);
                step();
            end
        end
        check("ack", ack_out, 1);
        check("cmd_out", cmd_out, v.exp_cmd);
        check("flags", {crc_err, timeout_err}, {v.exp_crc_err, v.exp_tmo});
        ok = 1'b1;
        for (int h = 0; h < v.hold; h++) begin
            step();
            ok = ok & ack_out & !cmd_pin_oe & !serial_ready;
        end
        if (v.hold > 0) check("ack_hold", ok, 1);
        req_in = 1'b0;
        step();
        check("ack_drop", {ack_out, serial_ready}, 2'b01);
    endtask

    function automatic vec_t mk(input logic [5:0] idx, input logic [31:0] arg, input int mode,
                                input logic [39:0] resp, input logic [6:0] cx, input logic eb,
                                input int delay, input int hold, input logic [47:0] ef,
                                input logic [39:0] ec, input logic ece, input logic et);
        vec_t v;
        v.idx = idx; v.arg = arg; v.mode = mode; v.resp = resp; v.crc_xor = cx;
        v.end_bit = eb; v.delay = delay; v.hold = hold; v.exp_frame = ef;
        v.exp_cmd = ec; v.exp_crc_err = ece; v.exp_tmo = et;
        return v;
    endfunction

    vec_t tbl[$];

    initial begin
        vec_t        v;
        logic [39:0] c;
        int          r;

        reset      = 1'b1;
        req_in     = 1'b0;
        cmd_in     = '0;
        cmd_pin_in = 1'b1;
        repeat (3) step();
        check("reset_state", {ack_out, cmd_out, serial_ready, crc_err, timeout_err, cmd_pin_out,
                              cmd_pin_oe}, {1'b0, 40'h0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0});
        reset = 1'b0;
        step();

        tbl.push_back(mk(6'd0, 32'h0, 0, 40'h0, 7'h0, 1'b1, 0, 0,
                         48'h40_0000_0000_95, 40'h0, 1'b0, 1'b0));
        tbl.push_back(mk(6'd8, 32'h1AA, 0, 40'h08_0000_01AA, 7'h0, 1'b1, 4, 2,
                         48'h48_0000_01AA_87, 40'h08_0000_01AA, 1'b0, 1'b0));
        tbl.push_back(mk(6'd17, 32'h0, 0, 40'h11_0000_0900, 7'h1, 1'b1, 4, 0,
                         48'h51_0000_0000_55, 40'h11_0000_0900, 1'b1, 1'b0));
        tbl.push_back(mk(6'd17, 32'h0, 1, 40'h0, 7'h0, 1'b1, 0, 10,
                         48'h51_0000_0000_55, 40'h0, 1'b0, 1'b1));
        tbl.push_back(mk(6'd8, 32'h1AA, 0, 40'h08_0000_01AA, 7'h0, 1'b1, 2, 0,
                         48'h48_0000_01AA_87, 40'h08_0000_01AA, 1'b0, 1'b0));
        tbl.push_back(mk(6'd17, 32'h0, 0, 40'h11_0000_0900, 7'h0, 1'b0, 7, 1,
                         48'h51_0000_0000_55, 40'h11_0000_0900, 1'b1, 1'b0));
        foreach (tbl[i]) run(tbl[i]);

        // Reset in the 20th SEND cycle abandons the frame.
        req_in = 1'b1;
        cmd_in = {2'b01, 6'd17, 32'h0};
        step();
        repeat (20) step();
        reset  = 1'b1;
        req_in = 1'b0;
        step();
        check("reset_mid_send", {cmd_pin_oe, cmd_pin_out, serial_ready, ack_out}, 4'b0110);
        reset = 1'b0;
        r = 0;
        repeat (5) begin
            step();
            r += int'(ack_out) + int'(cmd_pin_oe);
        end
        check("no_ack_after_reset", r, 0);
        run(tbl[0]);

        for (int i = 0; i < 14; i++) begin
            v.idx     = ($urandom_range(0, 4) == 0) ? 6'd0 : 6'($urandom_range(1, 63));
            v.arg     = $urandom();
            r         = $urandom_range(0, 3);
            v.mode    = (r == 1) ? 1 : 0;
            v.resp    = {2'b00, 6'($urandom()), 32'($urandom())};
            v.crc_xor = (r == 2) ? 7'(7'd1 << $urandom_range(0, 6)) : 7'd0;
            v.end_bit = (r != 3);
            v.delay   = $urandom_range(2, 30);
            v.hold    = $urandom_range(0, 3);
            c         = {2'b01, v.idx, v.arg};
            v.exp_frame = {c, crc7_ref(c), 1'b1};
            if (v.idx == 6'd0 || r == 1) v.exp_cmd = '0;
            else v.exp_cmd = v.resp;
            v.exp_crc_err = (v.idx != 6'd0) && (r == 2 || r == 3);
            v.exp_tmo     = (v.idx != 6'd0) && (r == 1);
            run(v);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/cmd_serial_host.md
# cmd_serial_host

Serial side of the SD host command path. Accepts a 40-bit command frame from `cmd_controller` over a four-phase req/ack handshake, appends CRC7 and end bit, and shifts the 48-bit frame MSB-first onto the CMD line. It then releases the line, waits for the card's 48-bit response, and checks its CRC. The response payload is returned to the controller with error flags.

## Interface
- `RESP_TIMEOUT`, 64: cycles allowed in WAIT_START before the response is declared missing (Ncr limit).
- `TURN_CYCLES`, 2: cycles the line is released between the command end bit and the first response sample.
- `clock` in 1: single clock; one CMD bit per cycle.
- `reset` in 1: synchronous, active-high.
- `req_in` in 1: controller request; level, held until `ack_out` is seen.
- `cmd_in` in 40: frame {start 0, transmission 1, index[5:0], argument[31:0]}; sampled when the request is accepted.
- `ack_out` out 1: transaction complete; `cmd_out`/error flags valid while high.
- `cmd_out` out 40: response bits 47..8 (start, transmission, index, 32-bit status).
- `serial_ready` out 1: high only in IDLE.
- `crc_err` out 1: response CRC mismatch or end bit 0.
- `timeout_err` out 1: no start bit within `RESP_TIMEOUT`.
- `cmd_pin_out` out 1: CMD line drive value.
- `cmd_pin_oe` out 1: CMD line output enable.
- `cmd_pin_in` in 1: CMD line sampled value (pulled up; idle 1).

## Operation
- States: IDLE, SEND, TURN, WAIT_START, RECEIVE, CHECK, ACK.
- IDLE: `serial_ready`=1. If `req_in`=1, latch `cmd_in`, clear the CRC and both error flags, then go to SEND.
- SEND: 48 cycles with `cmd_pin_oe`=1. Drive bits 39..0 of the latched frame, then CRC7[6:0], then end bit 1.
- After SEND, index 0 (CMD0) expects no response: go to ACK with `cmd_out`=0. All other indices go to TURN.
- TURN: `TURN_CYCLES` cycles with `cmd_pin_oe`=0 and `cmd_pin_out`=1; line not sampled.
- WAIT_START: sample `cmd_pin_in` each cycle.
  - 0 is the start bit and is shifted in as bit 47; go to RECEIVE.
  - After `RESP_TIMEOUT` samples of 1: set `timeout_err`, set `cmd_out`=0, go to ACK.
- RECEIVE: 47 more bits. CRC7 accumulates over response bits 47..8; bits 7..1 are the received CRC; bit 0 is the end bit.
- CHECK: one cycle. Load `cmd_out` from bits 47..8. Set `crc_err` if the computed and received CRC differ or the end bit is 0. Go to ACK.
- ACK: `ack_out`=1. When `req_in`=0, drop `ack_out` and return to IDLE. `cmd_out` and the flags hold until the next accept.
- CRC7: polynomial x^7+x^3+1, init 0, serial over 40 bits.
- `req_in` changes outside IDLE/ACK are ignored; `cmd_in` is not re-sampled.
- Response length is fixed at 48 bits; 136-bit R2 is out of scope.

## Timing
- Reset values: `ack_out`=0, `cmd_out`=0, `serial_ready`=1, `crc_err`=0, `timeout_err`=0, `cmd_pin_out`=1, `cmd_pin_oe`=0; state IDLE.
- Accept at edge N: the start bit is on the pin in cycle N+1, and the end bit in cycle N+48.
- `cmd_pin_oe` falls at edge N+49. The first possible response sample is cycle N+49+`TURN_CYCLES`.
- If the start bit is sampled at edge M: end bit at edge M+47, CHECK in the next cycle, `ack_out` high in the cycle after CHECK.
- No-response command: `ack_out` is high one cycle after the end bit.
- Timeout: `ack_out` rises `RESP_TIMEOUT`+1 cycles after WAIT_START is entered.
- `req_in` held high in ACK: `ack_out` stays high, with no re-trigger.
- Reset in any state: IDLE at the next edge; `cmd_pin_oe`=0 in the same cycle. A partial frame is abandoned with no ack.

## Structure
- Package `sd_cmd_pkg` holds:
  - state encoding;
  - `CMD_FRAME_BITS`=48, `CMD_PAYLOAD_BITS`=40;
  - CRC7 polynomial constant;
  - default `RESP_TIMEOUT` and `TURN_CYCLES`;
  - `CMD_NO_RESP_INDEX`=0.
- Sub-module `sd_crc7`: serial CRC7 with clear, enable, bit_in and crc[6:0] out. One instance is shared by the TX and RX phases.
- 6-bit bit counter and a timeout counter sized from `RESP_TIMEOUT`.

## Test plan
- CMD0, argument 0 → pin shows 0x40_0000_0000_95, no response phase, `ack_out`=1 at N+49 with `cmd_out`=0 and both flags 0.
- CMD8, argument 0x1AA → pin shows 0x48_0000_01AA_87. Card model answers 4 cycles after release with 0x08_0000_01AA plus model CRC → `cmd_out`=0x08000001AA, `crc_err`=0.
- CMD17, argument 0 → pin shows 0x51_0000_0000_55. Response CRC bit 0 flipped → `crc_err`=1, `cmd_out` still loaded.
- CMD17 with line held at 1 → `timeout_err`=1, `cmd_out`=0, `ack_out` 65 cycles after WAIT_START entry; `req_in` then held 10 extra cycles → `ack_out` stays 1, no new frame.
- Reset asserted in the 20th SEND cycle → next cycle `cmd_pin_oe`=0, `cmd_pin_out`=1, `serial_ready`=1; a following CMD0 transmits correctly.
- Back-to-back: `req_in` dropped and re-raised one cycle after `ack_out` falls → second frame starts exactly one cycle after acceptance, and error flags clear.
